// File: rtl/comb_eval_scheduler.sv
// rtl/comb_eval_scheduler.sv - round-robin sharing of one 4-in/3-out combinational evaluator
// Optional golden-model checker enabled by defining EVAL_CHECK_EN.
module comb_eval_scheduler #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] opnd,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        eval_abcd,
  input  logic [2:0]        eval_xyz,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2:0]        rsp_xyz,
  input  logic              rsp_ready,
  output logic              chk_err
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [3:0]     op_q;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] win;
  logic           win_ok;
  logic [IDW:0]   sum;

  assign eval_abcd = op_q;

  // First requester at or after ptr, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    sum    = '0;
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, ptr} + (IDW+1)'(j);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      if (!win_ok && req[sum[IDW-1:0]]) begin
        win_ok = 1'b1;
        win    = sum[IDW-1:0];
      end
    end
  end

`ifdef EVAL_CHECK_EN
  logic a, b, c, d, ab, aob, cd;
  logic [2:0] model;

  assign {a, b, c, d} = op_q;
  assign ab  = a & b;
  assign aob = (a | b) & ~c & ~d;
  assign cd  = c & d;
  assign model = {(~a & ~b & ~cd) | aob,
                  ab ? (~c & ~d) : (c ^ d),
                  ~((ab | ~cd) ^ aob)};
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      op_q      <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_xyz   <= '0;
`ifdef EVAL_CHECK_EN
      chk_err   <= 1'b0;
`endif
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (win_ok) begin
            op_q     <= opnd[{win, 2'b00} +: 4];
            id_q     <= win;
            gnt[win] <= 1'b1;
            cnt      <= CW'(SETTLE - 1);
            state    <= EVAL;
          end
        end
        EVAL: begin
          // eval_xyz is only looked at on this exit edge, so earlier glitches are harmless.
          if (cnt == '0) begin
            rsp_xyz   <= eval_xyz;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef EVAL_CHECK_EN
            if (eval_xyz != model)
              chk_err <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
